// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam logic [31:0] TXDATA_OFS = 32'd0;
    localparam logic [31:0] STATUS_OFS = 32'd4;

    localparam int BUSY_BIT  = 0;
    localparam int FULL_BIT  = 1;
    localparam int OVF_BIT   = 2;
    localparam int COUNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fallthrough FIFO; pointers wrap modulo DEPTH, which need not be a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only entries between the pointers are ever observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a FIFO, STATUS reports busy/full/overflow/count.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic        we,
    output logic [31:0] dout,
    output logic        tx
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    uart_state_t       state_q, state_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic              tx_q, tx_d;
    logic              ovf_q, ovf_d;

    logic              wr_txdata;
    logic              wr_status;
    logic              fifo_pop;
    logic [7:0]        fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              baud_wrap;
    logic              busy;
    logic              unused_din_hi;

    assign unused_din_hi = ^din[31:8];

    assign wr_txdata = we && (addr == BASE_ADDR + TXDATA_OFS);
    assign wr_status = we && (addr == BASE_ADDR + STATUS_OFS);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (wr_txdata),
        .din     (din[7:0]),
        .pop     (fifo_pop),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign baud_wrap = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign busy      = (state_q != IDLE) || (fifo_count != '0);
    assign tx        = tx_q;

    always_comb begin
        dout = '0;
        if (addr == BASE_ADDR + STATUS_OFS) begin
            dout[BUSY_BIT]          = busy;
            dout[FULL_BIT]          = fifo_full;
            dout[OVF_BIT]           = ovf_q;
            dout[COUNT_LSB +: 8]    = 8'(fifo_count);
        end
    end

    always_comb begin
        // Fullness is the pre-edge view, so a concurrent pop never rescues a dropped byte.
        ovf_d = ovf_q;
        if (wr_status) begin
            ovf_d = 1'b0;
        end else if (wr_txdata && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        baud_d    = baud_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    baud_d   = '0;
                    state_d  = START;
                    tx_d     = 1'b0;
                end
            end
            START: begin
                if (baud_wrap) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    // Back-to-back frames: the next start bit follows the stop bit directly.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = START;
                        tx_d     = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            baud_q    <= '0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            baud_q    <= baud_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: bus writes/reads plus a cycle-exact serial receiver on tx.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] STAT = 32'h0000_1004;
    localparam int          CPB  = 4;

    logic        clk;
    logic        n_reset;
    logic [31:0] addr;
    logic [31:0] din;
    logic        we;
    logic [31:0] dout;
    logic        tx;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] data;
        logic       start_b;
        logic       stop_b;
        logic       stable;
        int         start_cyc;
    } frame_t;

    frame_t frames[$];

    uart_tx_mmio #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .addr    (addr),
        .din     (din),
        .we      (we),
        .dout    (dout),
        .tx      (tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver: samples tx 1ns after every edge, one frame = 10*CPB samples, aborted by reset.
    initial begin : rx_mon
        logic   s [10*CPB];
        frame_t f;
        bit     aborted;
        forever begin
            @(posedge clk); #1;
            while (n_reset === 1'b1 && tx === 1'b0) begin
                f.start_cyc = cyc;
                aborted     = 1'b0;
                s[0]        = tx;
                for (int i = 1; i < 10*CPB; i++) begin
                    @(posedge clk); #1;
                    if (n_reset !== 1'b1) aborted = 1'b1;
                    s[i] = tx;
                end
                if (!aborted) begin
                    f.stable = 1'b1;
                    for (int k = 0; k < 10; k++)
                        for (int j = 1; j < CPB; j++)
                            if (s[k*CPB+j] !== s[k*CPB]) f.stable = 1'b0;
                    for (int k = 1; k <= 8; k++) f.data[k-1] = s[k*CPB+1];
                    f.start_b = s[1];
                    f.stop_b  = s[9*CPB+1];
                    frames.push_back(f);
                end
                @(posedge clk); #1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int edge_cyc);
        @(negedge clk);
        addr = a;
        din  = d;
        we   = 1'b1;
        @(posedge clk); #1;
        we       = 1'b0;
        addr     = 32'h0;
        edge_cyc = cyc;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, dout, exp);
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        int k = 0;
        while (frames.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        chk(tag, frames.size(), n);
    endtask

    task automatic chk_frame(input string tag, input logic [7:0] exp_data, input int exp_start);
        frame_t f;
        f.data = 8'h00; f.start_b = 1'b1; f.stop_b = 1'b0; f.stable = 1'b0; f.start_cyc = -1;
        if (frames.size() > 0) f = frames.pop_front();
        chk({tag, "_data"}, f.data, exp_data);
        chk({tag, "_framing"}, {f.start_b, f.stop_b, f.stable}, 3'b011);
        chk({tag, "_start_cyc"}, f.start_cyc, exp_start);
    endtask

    task automatic idle_chk(input string tag, input int n);
        bit ok = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
            if (tx !== 1'b1) ok = 1'b0;
        end
        chk(tag, ok, 1'b1);
    endtask

    initial begin : stim
        int wc;
        int w0;
        int target;

        addr    = 32'h0;
        din     = 32'h0;
        we      = 1'b0;
        n_reset = 1'b1;
        #2 n_reset = 1'b0;
        #1;
        chk("rst_tx", tx, 1'b1);
        read_chk("rst_status", STAT, 32'h0);
        repeat (3) @(negedge clk);
        n_reset = 1'b1;

        // 1: idle after reset
        idle_chk("t1_idle_tx", 20);
        read_chk("t1_status", STAT, 32'h0);
        read_chk("t1_dout_txdata", BASE, 32'h0);
        read_chk("t1_dout_zero", 32'h0, 32'h0);

        // 2: single byte '7'
        bus_write(BASE, 32'h37, wc);
        read_chk("t2_status_queued", STAT, 32'h0000_0101);
        @(posedge clk); #1;
        read_chk("t2_status_busy", STAT, 32'h0000_0001);
        wait_frames("t2_frames", 1, 60);
        chk_frame("t2_f0", 8'h37, wc + 1);
        repeat (2) @(posedge clk);
        #1;
        read_chk("t2_status_done", STAT, 32'h0);

        // 3: "55" back to back
        bus_write(BASE, 32'h35, wc);
        bus_write(BASE, 32'h35, w0);
        wait_frames("t3_frames", 2, 120);
        chk_frame("t3_f0", 8'h35, wc + 1);
        chk_frame("t3_f1", 8'h35, wc + 1 + 10*CPB);
        repeat (2) @(posedge clk);
        #1;
        read_chk("t3_status_done", STAT, 32'h0);

        // 4: overflow with six consecutive writes
        bus_write(BASE, 32'h41, w0);
        for (int i = 1; i < 6; i++) bus_write(BASE, 32'h41 + i, wc);
        read_chk("t4_status_ovf", STAT, 32'h0000_0407);
        read_chk("t4_dout_txdata", BASE, 32'h0);
        bus_write(STAT, 32'h0, wc);
        read_chk("t4_status_clr", STAT, 32'h0000_0403);
        wait_frames("t4_frames", 5, 250);
        for (int i = 0; i < 5; i++)
            chk_frame($sformatf("t4_f%0d", i), 8'(8'h41 + i), w0 + 1 + i*10*CPB);
        repeat (2) @(posedge clk);
        #1;
        read_chk("t4_status_done", STAT, 32'h0);
        chk("t4_no_extra", frames.size(), 0);

        // 5: reset during DATA bit 3 with two bytes still queued
        bus_write(BASE, 32'h55, w0);
        bus_write(BASE, 32'h55, wc);
        bus_write(BASE, 32'h55, wc);
        target = w0 + 1 + CPB + 3*CPB + 1;
        while (cyc < target) begin
            @(posedge clk); #1;
        end
        chk("t5_tx_bit3", tx, 1'b0);
        read_chk("t5_status_pre", STAT, 32'h0000_0201);
        #1 n_reset = 1'b0;
        #1;
        chk("t5_tx_async", tx, 1'b1);
        read_chk("t5_status_in_rst", STAT, 32'h0);
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        #1;
        read_chk("t5_status_post", STAT, 32'h0);
        idle_chk("t5_idle_tx", 100);
        chk("t5_no_frame", frames.size(), 0);

        // 6: writes outside TXDATA/STATUS
        bus_write(BASE + 32'd8, 32'h55, wc);
        bus_write(32'h0, 32'h55, wc);
        read_chk("t6_status", STAT, 32'h0);
        idle_chk("t6_idle_tx", 60);
        chk("t6_no_frame", frames.size(), 0);
        read_chk("t6_dout_base8", BASE + 32'd8, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter that acts as a responder on the CPU data bus (addr / writeData / we / readData).
- The CPU stores bytes to a TXDATA register. The block buffers them in a small FIFO and serialises them as 8N1 frames on a `tx` pin.
- The CPU polls a STATUS register for busy, full and overflow.
- It sits beside the data RAM. Its readData contribution is 0 outside its own window, so the interconnect can OR it with the RAM output.

Parameters:
- BASE_ADDR, 32'h0000_1000, address of TXDATA. STATUS is at BASE_ADDR+4.
- CLKS_PER_BIT, 16, clock cycles per serial bit. Must be ≥ 2.
- FIFO_DEPTH, 4, byte entries in the TX FIFO. Must be 2..7.

Ports:
- clk  in  1  system clock, rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- addr  in  32  data-bus address from the CPU.
- din  in  32  data-bus write data. Only [7:0] is used for TXDATA.
- we  in  1  data-bus write strobe, sampled at posedge clk.
- dout  out  32  data-bus read data, combinational from addr.
- tx  out  1  serial output; idle high.

Behaviour:
- Reset (async, n_reset=0):
  - tx=1; FSM goes to IDLE; FIFO empties; overflow flag=0; shift register, bit counter and baud counter go to 0.
  - Takes effect immediately, including mid-frame. The partial frame is abandoned.
- Write decode (at posedge clk when we=1):
  - addr==BASE_ADDR: push din[7:0] if the FIFO is not full.
  - If full (judged on the pre-edge count), drop the byte and set overflow=1. This holds even if a pop occurs in the same cycle.
  - addr==BASE_ADDR+4: any write clears overflow to 0.
  - Any other address: no effect.
- Read decode (combinational):
  - addr==BASE_ADDR+4: dout = {16'b0, count[7:0], 5'b0, overflow, full, busy}.
  - All other addresses, including TXDATA: dout = 0.
- Status fields:
  - busy = (state != IDLE) || (count != 0).
  - full = (count == FIFO_DEPTH).
  - count is the number of FIFO entries, zero-extended into [15:8].
- FSM states and transitions:
  - IDLE: tx=1. If count != 0, pop the head into the shift register, clear the baud counter and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles; shift right after each bit. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end:
    - if count != 0, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- Latency:
  - A write at edge N makes count=1 after edge N.
  - The pop at edge N+1 sets state=START, so tx falls after edge N+1.
  - One frame occupies exactly 10×CLKS_PER_BIT cycles on tx.
- Simultaneous push and pop with FIFO not full: count is unchanged and both take effect.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. The state/bit advance occurs on the wrap edge.
- FIFO pointers wrap modulo FIFO_DEPTH. The count width holds 0..FIFO_DEPTH.

Decomposition:
- Package uart_pkg:
  - typedef enum uart_state_t {IDLE, START, DATA, STOP};
  - localparams TXDATA_OFS=0, STATUS_OFS=4;
  - status bit positions BUSY_BIT=0, FULL_BIT=1, OVF_BIT=2, COUNT_LSB=8.
- One sub-module, sync_fifo:
  - parameters WIDTH, DEPTH;
  - ports clk, n_reset, push, din, pop, dout, count, full, empty;
  - first-word-fallthrough output.
- Bus decode, FSM, baud/bit counters and shift register stay in uart_tx_mmio.

Test Plan:
1. Reset with CLKS_PER_BIT=4, then idle 20 cycles → tx=1 throughout; STATUS read = 0x00000000; dout=0 at addr BASE_ADDR and at 0x0.
2. Single write of 0x37 ('7') to BASE_ADDR → tx shows start 0, then bits 1,1,1,0,1,1,0,0, then stop 1, each held 4 cycles (40 cycles total). STATUS busy=1 during the frame; STATUS = 0 after it.
3. Writes of 0x35, 0x35 ("55") on consecutive cycles → two contiguous frames, 80 cycles total. The first stop bit is followed immediately by the second start bit, and the received bytes match.
4. Overflow, FIFO_DEPTH=4: six writes 0x41..0x46 on consecutive cycles.
   - 0x41..0x45 are accepted (the first is popped a cycle after it is written); 0x46 is dropped.
   - STATUS = 0x00000407 (count=4, overflow, full, busy).
   - Five frames 0x41..0x45 are transmitted.
   - A write to BASE_ADDR+4 → overflow reads 0.
5. Reset mid-frame: n_reset low during DATA bit 3 of 0x55, with 2 bytes queued → tx=1 asynchronously; after release STATUS = 0 and no frame appears for 100 cycles.
6. Decode negatives: writes of 0x55 to BASE_ADDR+8 and to 0x0 → no frame and STATUS unchanged. A read of BASE_ADDR+8 → dout=0.
